// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory freeze with timeout HALT.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemRead_EX,
   input  logic [4:0]       targetReg_EX,
   input  logic [4:0]       Rn_ID,
   input  logic [4:0]       Rm_ID,
   input  logic             useRn_ID,
   input  logic             useRm_ID,
   input  logic             branchTaken_EX,
   input  logic             memReq_MEM,
   input  logic             memReady,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             bubble_EX,
   output logic             flush_IFID,
   output logic             freeze,
   output logic             memTimeout,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      MEMWAIT = 2'b01,
      HALT    = 2'b10
   } state_t;

   state_t        st_q, st_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          timeout_q, timeout_d;
   logic          load_use, mem_wait, run_eval;

   // R31 is the zero register, so a load targeting it never creates a dependency.
   assign load_use = MemRead_EX && (targetReg_EX != 5'd31) &&
                     ((useRn_ID && (Rn_ID == targetReg_EX)) ||
                      (useRm_ID && (Rm_ID == targetReg_EX)));
   assign mem_wait = memReq_MEM && !memReady;

   assign state      = st_q;
   assign memTimeout = timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q      <= RUN;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      st_d       = st_q;
      tcnt_d     = tcnt_q;
      timeout_d  = timeout_q;
      run_eval   = 1'b0;
      stall_IF   = 1'b0;
      stall_ID   = 1'b0;
      bubble_EX  = 1'b0;
      flush_IFID = 1'b0;
      freeze     = 1'b0;

      case (st_q)
         RUN: begin
            if (mem_wait) begin
               freeze = 1'b1;
               st_d   = MEMWAIT;
               tcnt_d = TW'(1);
            end else begin
               run_eval = 1'b1;
            end
         end
         MEMWAIT: begin
            if (memReady) begin
               run_eval = 1'b1;
               st_d     = RUN;
               tcnt_d   = '0;
            end else begin
               freeze = 1'b1;
               if (tcnt_q == TMAX) begin
                  st_d      = HALT;
                  timeout_d = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         HALT: begin
            freeze = 1'b1;
         end
         default: begin
            st_d = RUN;
         end
      endcase

      // A branch flushes the consumer of any coincident load-use, so it wins.
      if (run_eval) begin
         if (branchTaken_EX) begin
            flush_IFID = 1'b1;
            bubble_EX  = 1'b1;
         end else if (load_use) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_EX = 1'b1;
         end
      end

      if (reset) begin
         stall_IF   = 1'b0;
         stall_ID   = 1'b0;
         bubble_EX  = 1'b0;
         flush_IFID = 1'b0;
         freeze     = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((stall_IF || freeze) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_IFID && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;
`else
   assign stallCount = '0;
   assign flushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset, MemRead_EX, useRn_ID, useRm_ID, branchTaken_EX, memReq_MEM, memReady;
   logic [4:0]  targetReg_EX, Rn_ID, Rm_ID;
   logic        stall_IF, stall_ID, bubble_EX, flush_IFID, freeze, memTimeout;
   logic [1:0]  state;
   logic [15:0] stallCount, flushCount;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .MemRead_EX(MemRead_EX), .targetReg_EX(targetReg_EX),
      .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
      .branchTaken_EX(branchTaken_EX), .memReq_MEM(memReq_MEM), .memReady(memReady),
      .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
      .flush_IFID(flush_IFID), .freeze(freeze), .memTimeout(memTimeout),
      .state(state), .stallCount(stallCount), .flushCount(flushCount)
   );

   typedef struct {
      string       name;
      logic [4:0]  ctl;     // {stall_IF, stall_ID, bubble_EX, flush_IFID, freeze}
      logic [1:0]  st;
      logic        mt;
      logic        mask_mt;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [15:0] m_stall = '0;
   logic [15:0] m_flush = '0;
   logic [4:0]  act;

   localparam logic [4:0] Z = 5'b00000;
   localparam logic [4:0] L = 5'b11100;
   localparam logic [4:0] B = 5'b00110;
   localparam logic [4:0] F = 5'b00001;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         act = {stall_IF, stall_ID, bubble_EX, flush_IFID, freeze};
         checks++;
         if (act !== mon_e.ctl || state !== mon_e.st ||
             (!mon_e.mask_mt && memTimeout !== mon_e.mt)) begin
            errors++;
            $display("FAIL %s ctl: got ctl=%b state=%b memTimeout=%b, expected ctl=%b state=%b memTimeout=%b",
                     mon_e.name, act, state, memTimeout, mon_e.ctl, mon_e.st, mon_e.mt);
         end
         checks++;
         if (stallCount !== mon_e.sc || flushCount !== mon_e.fc) begin
            errors++;
            $display("FAIL %s counters: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                     mon_e.name, stallCount, flushCount, mon_e.sc, mon_e.fc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rst, input logic mr, input logic [4:0] tr,
                         input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                         input logic urm, input logic br, input logic mq, input logic rdy);
      reset = rst; MemRead_EX = mr; targetReg_EX = tr; Rn_ID = rn; Rm_ID = rm;
      useRn_ID = urn; useRm_ID = urm; branchTaken_EX = br; memReq_MEM = mq; memReady = rdy;
   endtask

   task automatic exp_cyc(input string nm, input logic [4:0] ctl, input logic [1:0] st,
                          input logic mt, input logic mask_mt);
      exp_t e;
      e.name = nm; e.ctl = ctl; e.st = st; e.mt = mt; e.mask_mt = mask_mt;
`ifdef HAZARD_PERF_CNT_EN
      e.sc = m_stall; e.fc = m_flush;
`else
      e.sc = '0; e.fc = '0;
`endif
      sb.push_back(e);
      if (reset) begin
         m_stall = '0;
         m_flush = '0;
      end else begin
         if ((ctl[4] || ctl[0]) && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
         if (ctl[1] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end
   endtask

   initial begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cyc("reset",        Z, 2'b00, 0, 0);

      // load-use detection and its boundaries
      tick(); set_in(0, 1,  5,  5, 0, 1, 0, 0, 0, 0); exp_cyc("loaduse_rn",   L, 2'b00, 0, 0);
      tick(); set_in(0, 0,  5,  5, 0, 1, 0, 0, 0, 0); exp_cyc("loaduse_gone", Z, 2'b00, 0, 0);
      tick(); set_in(0, 1, 31, 31, 0, 1, 0, 0, 0, 0); exp_cyc("rd31",         Z, 2'b00, 0, 0);
      tick(); set_in(0, 1,  7,  0, 7, 0, 1, 0, 0, 0); exp_cyc("loaduse_rm",   L, 2'b00, 0, 0);
      tick(); set_in(0, 1,  7,  7, 0, 0, 0, 0, 0, 0); exp_cyc("unused_src",   Z, 2'b00, 0, 0);
      tick(); set_in(0, 1,  5,  5, 0, 1, 0, 1, 0, 0); exp_cyc("br_over_lu",   B, 2'b00, 0, 0);
      tick(); set_in(0, 0,  0,  0, 0, 0, 0, 1, 0, 0); exp_cyc("branch",       B, 2'b00, 0, 0);

      // memory wait with a pending load-use, released after three frozen cycles
      tick(); set_in(0, 1, 5, 5, 0, 1, 0, 0, 1, 0); exp_cyc("mw1",          F, 2'b00, 0, 0);
      tick(); set_in(0, 1, 5, 5, 0, 1, 0, 0, 1, 0); exp_cyc("mw2",          F, 2'b01, 0, 0);
      tick(); set_in(0, 1, 5, 5, 0, 1, 0, 0, 1, 0); exp_cyc("mw3",          F, 2'b01, 0, 0);
      tick(); set_in(0, 1, 5, 5, 0, 1, 0, 0, 1, 1); exp_cyc("mw_release",   L, 2'b01, 0, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cyc("mw_run",       Z, 2'b00, 0, 0);

      // timeout: MEM_TIMEOUT=4, HALT after 5 frozen cycles
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("to1",          F, 2'b00, 0, 0);
      for (int i = 2; i <= 5; i++) begin
         tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc($sformatf("to%0d", i), F, 2'b01, 0, 0);
      end
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("halt",         F, 2'b10, 1, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); exp_cyc("halt_sticky",  F, 2'b10, 1, 0);
      tick(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cyc("halt_rst",     Z, 2'b10, 0, 1);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cyc("after_halt",   Z, 2'b00, 0, 0);

      // reset in the middle of a memory wait
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("rw1",          F, 2'b00, 0, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("rw2",          F, 2'b01, 0, 0);
      tick(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("rw_rst",       Z, 2'b01, 0, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("rw_follow",    F, 2'b00, 0, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_cyc("rw_wait",      F, 2'b01, 0, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); exp_cyc("rw_rel_br",    B, 2'b01, 0, 0);
      tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cyc("rw_end",       Z, 2'b00, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
